// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: N_REQ requesters share one registered bitwise logic unit.
// A round-robin arbiter picks one request at a time. The result goes out on a
// single response channel, tagged with the index of the requester that owns it.
//
// state | meaning
// IDLE  | waiting for any req_valid; grant and capture the winner's payload
// EXEC  | evaluate the captured opcode into the response registers
// RESP  | hold the response until rsp_ready is sampled high
module logic_op_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [15:0]            txn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nxt;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic             accept;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    int               idx;

    // Round-robin search starting at ptr; the first valid index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[IDW-1:0];
            end
        end
        ptr_nxt = IDW'((int'(grant_idx) + 1) % N_REQ);
    end

    assign accept = (state == IDLE) && grant_found;

    // One-hot grant, only in IDLE and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (!rst && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, arbitration pointer and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            txn_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr <= ptr_nxt;
            end
            if (state == RESP && rsp_ready) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

    // Payload capture at accept; later operand changes cannot reach the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rsp_id <= '0;
        end else if (accept) begin
            op_q   <= req_op[3*int'(grant_idx) +: 3];
            a_q    <= req_a[WIDTH*int'(grant_idx) +: WIDTH];
            b_q    <= req_b[WIDTH*int'(grant_idx) +: WIDTH];
            rsp_id <= grant_idx;
        end
    end

    // Logic unit: evaluated once in EXEC, held stable through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_err <= 1'b0;
            case (op_q)
                3'd0:    rsp_data <= a_q & b_q;
                3'd1:    rsp_data <= a_q | b_q;
                3'd2:    rsp_data <= ~a_q;
                3'd3:    rsp_data <= ~(a_q & b_q);
                3'd4:    rsp_data <= ~(a_q | b_q);
                3'd5:    rsp_data <= a_q ^ b_q;
                3'd6:    rsp_data <= ~(a_q ^ b_q);
                default: begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
